seq_mag_comp: RTL

SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

---
 rtl/seq_mag_comp_pkg.sv | 18 +
 rtl/seq_mag_comp_chunk_cmp.sv | 16 +
 rtl/seq_mag_comp.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_mag_comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// one-hot {l, e, g} result encoding.
package seq_mag_comp_pkg;

  typedef enum logic {
    StIdle,
    StCmp
  } state_t;

  // Bit order is {l, e, g}
  typedef logic [2:0] res_t;

  localparam res_t ResNone = 3'b000;
  localparam res_t ResL    = 3'b100;
  localparam res_t ResE    = 3'b010;
  localparam res_t ResG    = 3'b001;

endpackage

// File: rtl/seq_mag_comp_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module chunk_cmp #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/seq_mag_comp.sv
// Cascadable unsigned magnitude comparator that walks the operands one
// CHUNK-bit slice per cycle, MSB first, stopping at the first difference.
module seq_mag_comp
  import seq_mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             lin,
  input  logic             ein,
  input  logic             gin,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t             state_q;
  logic [IdxW-1:0]    idx_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               lin_q, ein_q, gin_q;
  res_t               res_q;
  logic               done_q;

  logic [31:0]        base;
  logic [CHUNK-1:0]   a_sl, b_sl;
  logic               s_lt, s_eq, s_gt;
  logic               mag_mode;

  assign base = 32'(idx_q) * CHUNK;
  assign a_sl = a_q[base +: CHUNK];
  assign b_sl = b_q[base +: CHUNK];

  // Equal-in, or no cascade opinion at all, defers to the operands
  assign mag_mode = ein_q | ~(gin_q | lin_q);

  chunk_cmp #(
    .CHUNK (CHUNK)
  ) u_chunk_cmp (
    .a  (a_sl),
    .b  (b_sl),
    .lt (s_lt),
    .eq (s_eq),
    .gt (s_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lin_q   <= 1'b0;
      ein_q   <= 1'b0;
      gin_q   <= 1'b0;
      res_q   <= ResNone;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            lin_q   <= lin;
            ein_q   <= ein;
            gin_q   <= gin;
            idx_q   <= IdxW'(NCHUNK - 1);
            state_q <= StCmp;
          end
        end
        StCmp: begin
          if (!mag_mode) begin
            res_q   <= gin_q ? ResG : ResL;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (s_lt) begin
            res_q   <= ResL;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (s_gt) begin
            res_q   <= ResG;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (s_eq && (idx_q == '0)) begin
            res_q   <= ResE;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StCmp);
  assign done = done_q;
  assign l    = res_q[2];
  assign e    = res_q[1];
  assign g    = res_q[0];

endmodule
